meter_timer_ctrl: RTL and testbench

Countdown controller for the project 4 parking-meter timer. It takes the single-cycle button pulses from the button controller and the two preset switches, and keeps a saturating 0–9999 second count that decrements once per second. It drives the 4-digit BCD value and a display-enable (blink) signal to the 7-segment driver, and flags expiry.

---
 rtl/meter_timer_ctrl.sv | 112 +++++++++++
 tb/tb_meter_timer_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/meter_timer_ctrl.sv
// Parking-meter countdown: saturating 0..9999 s counter with add pulses, preset
// switches, a 1 s prescaler, BCD readout and blink control for the display.
module meter_timer_ctrl #(
  parameter int TICK_CYCLES = 100_000_000,  // even, >= 4
  parameter int ADD_U       = 10,
  parameter int ADD_L       = 180,
  parameter int ADD_R       = 200,
  parameter int ADD_D       = 550,
  parameter int PRESET0     = 15,
  parameter int PRESET1     = 185
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pulse_btnu,
  input  logic        pulse_btnl,
  input  logic        pulse_btnr,
  input  logic        pulse_btnd,
  input  logic        sw0,
  input  logic        sw1,
  output logic [15:0] time_bcd,
  output logic        disp_on,
  output logic        expired,
  output logic        tick
);

  localparam int PW = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_CYCLES - 1);
  localparam logic [PW-1:0] PRE_HALF = PW'(TICK_CYCLES / 2);
  localparam logic [14:0]   CNT_MAX  = 15'd9999;
  localparam logic [13:0]   BLINK_SLOW_BELOW = 14'd200;

  logic [13:0]   cnt, cnt_next;
  logic [PW-1:0] prescaler, prescaler_next;
  logic          parity, parity_next;

  logic [14:0] add_sum;
  logic [14:0] raw_sum;
  logic [14:0] sat_sum;

  function automatic logic [15:0] bin_to_bcd(input logic [13:0] bin);
    logic [15:0] bcd;
    bcd = '0;
    // Shift-and-add-3: any digit >= 5 is corrected before it is doubled.
    for (int i = 13; i >= 0; i--) begin
      for (int d = 0; d < 4; d++) begin
        if (bcd[d*4 +: 4] >= 4'd5) bcd[d*4 +: 4] = bcd[d*4 +: 4] + 4'd3;
      end
      bcd = {bcd[14:0], bin[i]};
    end
    return bcd;
  endfunction

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      cnt       <= '0;
      prescaler <= '0;
      parity    <= 1'b0;
    end else begin
      cnt       <= cnt_next;
      prescaler <= prescaler_next;
      parity    <= parity_next;
    end
  end

  assign tick = (prescaler == PRE_LAST);

  // Add path is 15 bits wide so 9999 + 940 cannot wrap before saturation.
  always_comb begin
    add_sum = (pulse_btnu ? 15'(ADD_U) : 15'd0)
            + (pulse_btnl ? 15'(ADD_L) : 15'd0)
            + (pulse_btnr ? 15'(ADD_R) : 15'd0)
            + (pulse_btnd ? 15'(ADD_D) : 15'd0);
    raw_sum = {1'b0, cnt} + add_sum;
    sat_sum = (raw_sum > CNT_MAX) ? CNT_MAX : raw_sum;
  end

  // Next-state logic
  always_comb begin
    // NOTE: every output of this block is assigned up front so no path leaves
    // a variable unassigned, which would otherwise infer a latch.
    cnt_next       = cnt;
    prescaler_next = prescaler;
    parity_next    = parity;

    if (sw0) begin
      cnt_next       = 14'(PRESET0);
      prescaler_next = '0;
      parity_next    = 1'b0;
    end else if (sw1) begin
      cnt_next       = 14'(PRESET1);
      prescaler_next = '0;
      parity_next    = 1'b0;
    end else begin
      cnt_next       = (tick && sat_sum != 15'd0) ? 14'(sat_sum - 15'd1) : sat_sum[13:0];
      prescaler_next = tick ? '0 : prescaler + PW'(1);
      parity_next    = parity ^ tick;
    end
  end

  // Output decode
  always_comb begin
    time_bcd = bin_to_bcd(cnt);
    expired  = (cnt == 14'd0);
    disp_on  = 1'b1;
    if (cnt == 14'd0)                disp_on = (prescaler < PRE_HALF);
    else if (cnt < BLINK_SLOW_BELOW) disp_on = ~parity;
  end

endmodule

// File: tb/tb_meter_timer_ctrl.sv
// Scoreboard bench for meter_timer_ctrl: a behavioural model queues the expected
// outputs for each driven cycle, compared after the edge, plus directed checks.
module tb_meter_timer_ctrl;

  localparam int TC = 10;

  logic        clk = 1'b0;
  logic        reset, pulse_btnu, pulse_btnl, pulse_btnr, pulse_btnd, sw0, sw1;
  logic [15:0] time_bcd;
  logic        disp_on, expired, tick;

  typedef struct packed {
    logic [15:0] bcd;
    logic        disp;
    logic        exp;
    logic        tck;
  } exp_t;

  exp_t sb_q[$];
  int   m_cnt, m_pre;
  bit   m_par;
  int   n_checks, n_fail;

  always #5 clk = ~clk;

  meter_timer_ctrl #(
    .TICK_CYCLES(TC), .ADD_U(10), .ADD_L(180), .ADD_R(200), .ADD_D(550),
    .PRESET0(15), .PRESET1(185)
  ) dut (
    .clk(clk), .reset(reset),
    .pulse_btnu(pulse_btnu), .pulse_btnl(pulse_btnl),
    .pulse_btnr(pulse_btnr), .pulse_btnd(pulse_btnd),
    .sw0(sw0), .sw1(sw1),
    .time_bcd(time_bcd), .disp_on(disp_on), .expired(expired), .tick(tick)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.bcd = {4'(m_cnt / 1000), 4'((m_cnt / 100) % 10), 4'((m_cnt / 10) % 10), 4'(m_cnt % 10)};
    e.exp = (m_cnt == 0);
    e.tck = (m_pre == TC - 1);
    if (m_cnt == 0)       e.disp = (m_pre < TC / 2);
    else if (m_cnt < 200) e.disp = !m_par;
    else                  e.disp = 1'b1;
    return e;
  endfunction

  // Drive one cycle of inputs, advance the model, then compare after the edge.
  task automatic cycle(input bit rst, input bit u, input bit l, input bit r,
                       input bit d, input bit s0, input bit s1);
    bit   t;
    int   s;
    exp_t e;
    reset = rst; pulse_btnu = u; pulse_btnl = l; pulse_btnr = r; pulse_btnd = d;
    sw0 = s0; sw1 = s1;
    t = (m_pre == TC - 1);
    if (rst) begin
      m_cnt = 0; m_pre = 0; m_par = 0;
    end else if (s0) begin
      m_cnt = 15; m_pre = 0; m_par = 0;
    end else if (s1) begin
      m_cnt = 185; m_pre = 0; m_par = 0;
    end else begin
      s = m_cnt + (u ? 10 : 0) + (l ? 180 : 0) + (r ? 200 : 0) + (d ? 550 : 0);
      if (s > 9999) s = 9999;
      if (t && s > 0) s = s - 1;
      m_cnt = s;
      m_pre = t ? 0 : m_pre + 1;
      m_par = m_par ^ t;
    end
    sb_q.push_back(model_out());
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check("sb_bcd", time_bcd, e.bcd);
    check("sb_disp_on", disp_on, e.disp);
    check("sb_expired", expired, e.exp);
    check("sb_tick", tick, e.tck);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wait_tick(input string tag, input int budget);
    for (int i = 0; i < budget && !tick; i++) idle(1);
    check(tag, tick, 1);
  endtask

  initial begin
    int n;
    reset = 1; pulse_btnu = 0; pulse_btnl = 0; pulse_btnr = 0; pulse_btnd = 0;
    sw0 = 0; sw1 = 0;
    n_checks = 0; n_fail = 0;

    // 1: reset, then idle
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0);
    check("t1_rst_bcd", time_bcd, 16'h0000);
    check("t1_rst_expired", expired, 1);
    check("t1_rst_disp", disp_on, 1);
    check("t1_rst_tick", tick, 0);
    n = 0;
    for (int i = 0; i < 25; i++) begin
      idle(1);
      if (tick) n++;
    end
    check("t1_tick_count", n, 2);
    check("t1_idle_bcd", time_bcd, 16'h0000);

    // 2: single btnd pulse, then first tick decrements
    cycle(0, 0, 0, 0, 1, 0, 0);
    check("t2_add550", time_bcd, 16'h0550);
    wait_tick("t2_tick_seen", 12);
    idle(1);
    check("t2_after_tick", time_bcd, 16'h0549);
    check("t2_disp", disp_on, 1);

    // 3: sw1 hold, release, first tick a full period later; sw0 beats sw1
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 0, 1);
    check("t3_load185", time_bcd, 16'h0185);
    check("t3_hold_no_tick", tick, 0);
    n = 0;
    for (int i = 0; i < 20 && time_bcd != 16'h0184; i++) begin
      idle(1);
      n++;
    end
    check("t3_first_tick_dist", n, 10);
    check("t3_disp_parity", disp_on, 0);
    cycle(0, 0, 0, 0, 0, 1, 1);
    check("t3_sw0_wins", time_bcd, 16'h0015);

    // 4: simultaneous pulses, saturation, add during tick at 9999
    cycle(0, 0, 0, 0, 0, 0, 1);
    cycle(0, 1, 1, 1, 1, 0, 0);
    check("t4_all_pulses", time_bcd, 16'h1125);
    for (int i = 0; i < 20; i++) cycle(0, 0, 0, 0, 1, 0, 0);
    check("t4_saturate", time_bcd, 16'h9999);
    for (int i = 0; i < 12 && !tick; i++) cycle(0, 0, 0, 0, 1, 0, 0);
    check("t4_tick_seen", tick, 1);
    check("t4_pre_tick_sat", time_bcd, 16'h9999);
    cycle(0, 1, 0, 0, 0, 0, 0);
    check("t4_sat_tick", time_bcd, 16'h9998);

    // 5: countdown from 15 to expiry, hold at 0, add during tick at 0
    cycle(0, 0, 0, 0, 0, 1, 0);
    check("t5_load15", time_bcd, 16'h0015);
    n = 0;
    for (int i = 0; i < 200 && !expired; i++) begin
      idle(1);
      n++;
    end
    check("t5_cycles_to_zero", n, 150);
    check("t5_expired", expired, 1);
    check("t5_zero_bcd", time_bcd, 16'h0000);
    idle(25);
    check("t5_hold_zero", time_bcd, 16'h0000);
    wait_tick("t5_tick_seen", 12);
    cycle(0, 1, 0, 0, 0, 0, 0);
    check("t5_add_at_zero", time_bcd, 16'h0009);

    // 6: reset mid-count overrides a pulse
    cycle(0, 0, 0, 0, 0, 0, 1);
    cycle(0, 1, 1, 1, 1, 0, 0);
    check("t6_pre_reset", time_bcd, 16'h1125);
    cycle(1, 0, 0, 0, 1, 0, 0);
    check("t6_rst_bcd", time_bcd, 16'h0000);
    check("t6_rst_tick", tick, 0);
    check("t6_rst_disp", disp_on, 1);
    n = 0;
    for (int i = 0; i < 15 && !tick; i++) begin
      idle(1);
      n++;
    end
    check("t6_prescaler_zero", n, 9);

    check("sb_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
